// File: rtl/buf_lookup_ctrl.sv
// Lookup/fill control in front of the 4-entry LFU replacement selector.
// Resolves hit/miss per request tag, runs victim selection and fill handshake, keeps stats.
module buf_lookup_ctrl #(
  parameter int TAG_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [TAG_W-1:0] req_tag,
  output logic             req_ready,
  output logic             hit_valid,
  output logic [1:0]       hit_buf,
  output logic             new_buf_req,
  output logic [1:0]       ref_buf_numbr,
  input  logic [1:0]       buf_num_replc,
  output logic             fill_req,
  output logic [1:0]       fill_buf,
  output logic [TAG_W-1:0] fill_tag,
  input  logic             fill_done,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  typedef enum logic [1:0] {IDLE, VREQ, VWAIT, FILL} state_t;

  state_t           state, state_nxt;
  logic [3:0]       ent_valid;
  logic [TAG_W-1:0] ent_tag [4];

  logic       hit;
  logic [1:0] hit_idx;
  logic       has_free;
  logic [1:0] free_idx;
  logic       accept;
  logic       fill_fire;

  assign accept    = (state == IDLE) && req_valid;
  assign fill_fire = (state == FILL) && fill_done;

  // Tag match and lowest-index free entry; at most one valid entry can match.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    has_free = 1'b0;
    free_idx = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (ent_valid[2'(i)] && (ent_tag[2'(i)] == req_tag)) begin
        hit     = 1'b1;
        hit_idx = 2'(i);
      end
      if (!ent_valid[2'(i)] && !has_free) begin
        has_free = 1'b1;
        free_idx = 2'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid && !hit) state_nxt = has_free ? FILL : VREQ;
      VREQ:    state_nxt = VWAIT;
      VWAIT:   state_nxt = FILL;
      FILL:    if (fill_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready   = (state == IDLE);
    new_buf_req = (state == VREQ);
    fill_req    = (state == FILL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent_valid     <= '0;
      for (int unsigned i = 0; i < 4; i++) ent_tag[2'(i)] <= '0;
      hit_valid     <= 1'b0;
      hit_buf       <= '0;
      ref_buf_numbr <= '0;
      fill_buf      <= '0;
      fill_tag      <= '0;
      hit_cnt       <= '0;
      miss_cnt      <= '0;
    end else begin
      hit_valid <= 1'b0;
      if (accept && hit) begin
        hit_valid     <= 1'b1;
        hit_buf       <= hit_idx;
        ref_buf_numbr <= hit_idx;
        if (hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
      end
      // Misses are counted at acceptance; the free entry is chosen here, a victim later.
      if (accept && !hit) begin
        fill_tag <= req_tag;
        if (miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
        if (has_free) fill_buf <= free_idx;
      end
      if (state == VWAIT) fill_buf <= buf_num_replc;
      if (fill_fire) begin
        ent_valid[fill_buf] <= 1'b1;
        ent_tag[fill_buf]   <= fill_tag;
        hit_valid           <= 1'b1;
        hit_buf             <= fill_buf;
        ref_buf_numbr       <= fill_buf;
      end
    end
  end

endmodule

// File: tb/tb_buf_lookup_ctrl.sv
// Bench for buf_lookup_ctrl: directed vectors, a tag-store model checked every cycle,
// and a second instance with 2-bit counters to exercise saturation.
module tb_buf_lookup_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic [7:0] req_tag = '0;
  logic [1:0] buf_num_replc = '0;
  logic       fill_done = 1'b0;

  logic        req_ready, hit_valid, new_buf_req, fill_req;
  logic [1:0]  hit_buf, ref_buf_numbr, fill_buf;
  logic [7:0]  fill_tag;
  logic [15:0] hit_cnt, miss_cnt;

  logic        s_req_ready, s_hit_valid, s_new_buf_req, s_fill_req;
  logic [1:0]  s_hit_buf, s_ref_buf_numbr, s_fill_buf;
  logic [7:0]  s_fill_tag;
  logic [1:0]  s_hit_cnt, s_miss_cnt;

  buf_lookup_ctrl #(.TAG_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_tag(req_tag), .req_ready(req_ready),
    .hit_valid(hit_valid), .hit_buf(hit_buf), .new_buf_req(new_buf_req),
    .ref_buf_numbr(ref_buf_numbr), .buf_num_replc(buf_num_replc), .fill_req(fill_req),
    .fill_buf(fill_buf), .fill_tag(fill_tag), .fill_done(fill_done),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  buf_lookup_ctrl #(.TAG_W(8), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_tag(req_tag), .req_ready(s_req_ready),
    .hit_valid(s_hit_valid), .hit_buf(s_hit_buf), .new_buf_req(s_new_buf_req),
    .ref_buf_numbr(s_ref_buf_numbr), .buf_num_replc(buf_num_replc), .fill_req(s_fill_req),
    .fill_buf(s_fill_buf), .fill_tag(s_fill_tag), .fill_done(fill_done),
    .hit_cnt(s_hit_cnt), .miss_cnt(s_miss_cnt)
  );

  initial forever #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // Model: the tag store plus which step of the request the controller is in.
  typedef enum {M_IDLE, M_VREQ, M_VWAIT, M_FILL} mphase_t;
  mphase_t    m_phase = M_IDLE;
  bit         m_valid [4] = '{default: 1'b0};
  logic [7:0] m_tag   [4] = '{default: 8'h00};
  bit         m_hv  = 1'b0;
  logic [1:0] m_hb  = '0;
  logic [1:0] m_ref = '0;
  logic [1:0] m_fb  = '0;
  logic [7:0] m_ft  = '0;
  int         n_hits = 0;
  int         n_miss = 0;
  int         k;

  function automatic int find_tag(input logic [7:0] t);
    for (int i = 0; i < 4; i++) if (m_valid[i] && m_tag[i] == t) return i;
    return -1;
  endfunction

  function automatic int first_free();
    for (int i = 0; i < 4; i++) if (!m_valid[i]) return i;
    return -1;
  endfunction

  function automatic int sat(input int n, input int w);
    return (n > (1 << w) - 1) ? (1 << w) - 1 : n;
  endfunction

  initial forever begin
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 4; i++) begin m_valid[i] = 1'b0; m_tag[i] = '0; end
      m_phase = M_IDLE; m_hv = 1'b0; m_hb = '0; m_ref = '0; m_fb = '0; m_ft = '0;
      n_hits = 0; n_miss = 0;
    end else begin
      m_hv = 1'b0;
      case (m_phase)
        M_IDLE: if (req_valid) begin
          k = find_tag(req_tag);
          if (k >= 0) begin
            m_hv = 1'b1; m_hb = 2'(k); m_ref = 2'(k); n_hits++;
          end else begin
            n_miss++; m_ft = req_tag;
            k = first_free();
            if (k >= 0) begin m_fb = 2'(k); m_phase = M_FILL; end
            else m_phase = M_VREQ;
          end
        end
        M_VREQ:  m_phase = M_VWAIT;
        M_VWAIT: begin m_fb = buf_num_replc; m_phase = M_FILL; end
        M_FILL: if (fill_done) begin
          m_valid[m_fb] = 1'b1; m_tag[m_fb] = m_ft;
          m_hv = 1'b1; m_hb = m_fb; m_ref = m_fb; m_phase = M_IDLE;
        end
        default: m_phase = M_IDLE;
      endcase
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("req_ready", req_ready, m_phase == M_IDLE);
      chk("new_buf_req", new_buf_req, m_phase == M_VREQ);
      chk("fill_req", fill_req, m_phase == M_FILL);
      chk("hit_valid", hit_valid, m_hv);
      if (m_hv) chk("hit_buf", hit_buf, m_hb);
      chk("ref_buf_numbr", ref_buf_numbr, m_ref);
      if (m_phase == M_FILL) begin
        chk("fill_buf", fill_buf, m_fb);
        chk("fill_tag", fill_tag, m_ft);
      end
      chk("hit_cnt", hit_cnt, sat(n_hits, 16));
      chk("miss_cnt", miss_cnt, sat(n_miss, 16));
      chk("sat_hit_cnt", s_hit_cnt, sat(n_hits, 2));
      chk("sat_miss_cnt", s_miss_cnt, sat(n_miss, 2));
    end
  end

  // Presents a tag for one cycle while IDLE; returns at the negedge of cycle c+1.
  task automatic drive_req(input logic [7:0] t);
    req_valid = 1'b1; req_tag = t;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Waits (bounded) for fill_req, delays dly cycles, pulses fill_done; returns at f+1.
  task automatic do_fill(input int dly);
    for (int i = 0; i < 16 && !fill_req; i++) @(negedge clk);
    chk("fill_req_wait", fill_req, 1'b1);
    repeat (dly) @(negedge clk);
    fill_done = 1'b1;
    @(negedge clk);
    fill_done = 1'b0;
  endtask

  // Called at c+1 of a miss with all entries valid; walks VREQ/VWAIT into FILL.
  task automatic victim_path(input logic [1:0] victim, input logic [7:0] t);
    chk("lit_new_buf_req_c1", new_buf_req, 1'b1);
    chk("lit_fill_req_c1", fill_req, 1'b0);
    buf_num_replc = victim;
    @(negedge clk);
    chk("lit_new_buf_req_c2", new_buf_req, 1'b0);
    @(negedge clk);
    chk("lit_fill_req_c3", fill_req, 1'b1);
    chk("lit_fill_buf_c3", fill_buf, victim);
    chk("lit_fill_tag_c3", fill_tag, t);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    chk("lit_reset_req_ready", req_ready, 1'b1);
    chk("lit_reset_fill_req", fill_req, 1'b0);
    chk("lit_reset_fill_buf", fill_buf, 2'd0);
    chk("lit_reset_fill_tag", fill_tag, 8'h00);
    chk("lit_reset_hit_cnt", hit_cnt, 16'd0);

    // 1: first miss takes free entry 0 without victim request; 1-cycle fill.
    drive_req(8'h11);
    chk("lit_t1_fill_req", fill_req, 1'b1);
    chk("lit_t1_fill_buf", fill_buf, 2'd0);
    chk("lit_t1_new_buf_req", new_buf_req, 1'b0);
    do_fill(0);
    chk("lit_t1_hit_valid", hit_valid, 1'b1);
    chk("lit_t1_hit_buf", hit_buf, 2'd0);
    chk("lit_t1_ref", ref_buf_numbr, 2'd0);

    // 2: fill the remaining free entries, then hit 0x33 in entry 2.
    drive_req(8'h22); chk("lit_t2_fill_buf_1", fill_buf, 2'd1); do_fill(1);
    drive_req(8'h33); chk("lit_t2_fill_buf_2", fill_buf, 2'd2); do_fill(0);
    drive_req(8'h44); chk("lit_t2_fill_buf_3", fill_buf, 2'd3); do_fill(2);
    drive_req(8'h33);
    chk("lit_t2_hit_valid", hit_valid, 1'b1);
    chk("lit_t2_hit_buf", hit_buf, 2'd2);
    chk("lit_t2_hit_cnt", hit_cnt, 16'd1);
    chk("lit_t2_miss_cnt", miss_cnt, 16'd4);

    // 3: all valid; 0x55 replaces entry 1, then 0x55 hits and 0x22 misses.
    drive_req(8'h55);
    victim_path(2'd1, 8'h55);
    do_fill(0);
    chk("lit_t3_hit_buf", hit_buf, 2'd1);
    drive_req(8'h55);
    chk("lit_t3_hit55", hit_valid, 1'b1);
    chk("lit_t3_hit55_buf", hit_buf, 2'd1);
    chk("lit_t3_sat_hit_cnt", s_hit_cnt, 2'd2);
    drive_req(8'h22);
    chk("lit_t3_miss22", hit_valid, 1'b0);
    victim_path(2'd3, 8'h22);
    do_fill(1);
    chk("lit_t3_miss_cnt", miss_cnt, 16'd6);

    // 4: request held through a slow fill is accepted only once more, at f+1.
    req_valid = 1'b1; req_tag = 8'h66;
    @(negedge clk);
    victim_path(2'd0, 8'h66);
    do_fill(5);
    chk("lit_t4_ready_f1", req_ready, 1'b1);
    chk("lit_t4_miss_cnt", miss_cnt, 16'd7);
    @(negedge clk);
    req_valid = 1'b0;
    chk("lit_t4_hit_valid", hit_valid, 1'b1);
    chk("lit_t4_hit_buf", hit_buf, 2'd0);
    chk("lit_t4_hit_cnt", hit_cnt, 16'd3);

    // 6: further hits saturate the 2-bit counters, the 16-bit ones keep counting.
    repeat (3) begin
      drive_req(8'h33);
      chk("lit_t6_hit_buf", hit_buf, 2'd2);
    end
    chk("lit_t6_hit_cnt", hit_cnt, 16'd6);
    chk("lit_t6_sat_hit_cnt", s_hit_cnt, 2'd3);
    chk("lit_t6_sat_miss_cnt", s_miss_cnt, 2'd3);

    // 5: reset mid-fill abandons it; the old tag then misses into entry 0.
    drive_req(8'h77);
    victim_path(2'd2, 8'h77);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("lit_t5_fill_req", fill_req, 1'b0);
    chk("lit_t5_req_ready", req_ready, 1'b1);
    chk("lit_t5_hit_cnt", hit_cnt, 16'd0);
    chk("lit_t5_miss_cnt", miss_cnt, 16'd0);
    drive_req(8'h66);
    chk("lit_t5_remiss", fill_req, 1'b1);
    chk("lit_t5_fill_buf", fill_buf, 2'd0);
    chk("lit_t5_no_vreq", new_buf_req, 1'b0);
    chk("lit_t5_miss_cnt1", miss_cnt, 16'd1);
    do_fill(2);
    chk("lit_t5_hit_buf", hit_buf, 2'd0);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
